// File: rtl/pipe_pkg.sv
// Shared widths, control-field layout and slot-update encoding for the
// decode/execute pipeline stage register.
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 9;

    localparam int CB_MEM_WRITE  = 0;
    localparam int CB_MEM_READ   = 1;
    localparam int CB_REG_WRITE  = 2;
    localparam int CB_REG_DST    = 3;
    localparam int CB_MEM_TO_REG = 4;
    localparam int CB_ALU_SRC    = 5;
    localparam int CB_ALU_OP_LO  = 6;
    localparam int CB_ALU_OP_HI  = 8;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_LOAD_IN,
        MAIN_LOAD_SKID,
        MAIN_CLEAR
    } main_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus ctrl/data payload with load and clear.
// Clear drops valid and ctrl but leaves data untouched.
module pipe_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
// The skid entry lets in_ready be a flop, cutting the out_ready->in_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
    logic              push, pop;
    main_op_e          main_op;

    assign push = in_valid && in_ready && !flush;
    assign pop  = main_v && out_ready;

    // While the skid entry is occupied in_ready is low, so a pop can only refill from skid.
    always_comb begin
        main_op = MAIN_HOLD;
        if (flush)
            main_op = MAIN_CLEAR;
        else if (skid_v) begin
            if (pop)
                main_op = MAIN_LOAD_SKID;
        end else if (push && (!main_v || pop))
            main_op = MAIN_LOAD_IN;
        else if (pop)
            main_op = MAIN_CLEAR;
    end

    assign main_ld_ctrl = (main_op == MAIN_LOAD_SKID) ? skid_ctrl : in_ctrl;
    assign main_ld_data = (main_op == MAIN_LOAD_SKID) ? skid_data : in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear   (main_op == MAIN_CLEAR),
        .load    (main_op == MAIN_LOAD_IN || main_op == MAIN_LOAD_SKID),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_v),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load, skid_clear;

            assign skid_load  = push && main_v && !pop;
            assign skid_clear = flush || (skid_v && pop);

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clear   (skid_clear),
                .load    (skid_load),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (skid_v),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            assign in_ready = !skid_v;
        end else begin : g_noskid
            assign skid_v    = 1'b0;
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign in_ready  = !main_v || out_ready;
        end
    endgenerate

    // Bubbles carry zero control so they can never write memory or registers.
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule
